imem_loader: RTL

Host-side program loader for the 16-bit MIPS pipeline: accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and writes them into instruction memory from address 0. It drives the data into the core's instruction memory, the opposite direction from the debug/readout path. While a load is in progress it holds the pipeline in reset. A trailing XOR checksum byte validates each image.

---
 rtl/imem_loader_pkg.sv | 33 +++
 rtl/imem_loader_if.sv | 33 +++
 rtl/imem_loader.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader FSM encoding, error codes and stream/word widths.
// Imported by the loader interface and the loader module.
package imem_loader_pkg;

    localparam int INSTR_W = 16;
    localparam int BYTE_W  = 8;
    localparam int LEN_W   = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN_HI  = 3'd1,
        ST_LEN_LO  = 3'd2,
        ST_DATA_HI = 3'd3,
        ST_DATA_LO = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CHK  = 2'd2
    } err_t;

    // A load is in progress (and the stream is open) exactly in these states.
    function automatic logic is_loading(state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Loader bus bundle: host byte stream in, instruction-memory write port out.
// No latency of its own; pure wiring between host, loader and memory.
// Stream uses valid/ready; the memory write port has no backpressure.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [imem_loader_pkg::BYTE_W-1:0]  in_data;
    logic                                in_valid;
    logic                                in_ready;
    logic                                imem_we;
    logic [ADDR_W-1:0]                   imem_addr;
    logic [imem_loader_pkg::INSTR_W-1:0] imem_wdata;

    // Host side: produces the byte stream and observes the memory writes.
    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    // Loader side: consumes the byte stream and drives the memory write port.
    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checked big-endian image into instruction memory from word 0.
// One byte per cycle; imem_we is registered and pulses the cycle after each LO byte is taken.
// in_ready is high only while loading; the host holds its byte whenever in_ready is low.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    imem_loader_if.slave      io,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int             DEPTH   = 1 << ADDR_W;
    localparam logic [LEN_W:0] DEPTH_L = (LEN_W + 1)'(DEPTH);

    state_t              state_q;
    state_t              state_d;
    logic                xfer;
    logic [BYTE_W-1:0]   len_hi_q;
    logic [LEN_W-1:0]    len_q;
    logic [BYTE_W-1:0]   hi_q;
    logic [BYTE_W-1:0]   acc_q;
    logic [LEN_W-1:0]    len_rx;
    logic [LEN_W-1:0]    words_ext;
    logic                len_too_big;
    logic                last_word;
    logic                chk_ok;

    // in_ready is a pure state decode so the host sees it without a pipeline bubble.
    assign io.in_ready = is_loading(state_q);
    assign xfer        = io.in_valid && io.in_ready;

    // Full word count as it completes in LEN_LO; only meaningful on that transfer.
    assign len_rx      = {len_hi_q, io.in_data};
    assign len_too_big = {1'b0, len_rx} > DEPTH_L;

    // The word being completed now is the last one when the count reaches N after it.
    assign words_ext   = LEN_W'(words_loaded);
    assign last_word   = (words_ext + LEN_W'(1)) == len_q;
    assign chk_ok      = (io.in_data == acc_q);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: advance on each accepted byte, start only from a resting state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    if (len_too_big) begin
                        state_d = ST_ERR;
                    end else if (len_rx == '0) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    state_d = last_word ? ST_CHECK : ST_DATA_HI;
                end
            end
            ST_CHECK: begin
                if (xfer) begin
                    state_d = chk_ok ? ST_DONE : ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status: busy follows the next state so it drops on entry to DONE/ERR.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_hi_q      <= '0;
            len_q         <= '0;
            hi_q          <= '0;
            acc_q         <= '0;
            io.imem_we    <= 1'b0;
            io.imem_addr  <= '0;
            io.imem_wdata <= '0;
            busy          <= 1'b0;
            cpu_hold      <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= ERR_NONE;
            words_loaded  <= '0;
        end else begin
            io.imem_we <= 1'b0;
            busy       <= is_loading(state_d);
            cpu_hold   <= is_loading(state_d);

            unique case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        err_code     <= ERR_NONE;
                        words_loaded <= '0;
                        acc_q        <= '0;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) begin
                        len_hi_q <= io.in_data;
                    end
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len_q <= len_rx;
                        if (len_too_big) begin
                            error    <= 1'b1;
                            err_code <= ERR_LEN;
                        end
                    end
                end
                ST_DATA_HI: begin
                    if (xfer) begin
                        hi_q  <= io.in_data;
                        acc_q <= acc_q ^ io.in_data;
                    end
                end
                ST_DATA_LO: begin
                    if (xfer) begin
                        io.imem_we    <= 1'b1;
                        io.imem_addr  <= words_loaded[ADDR_W-1:0];
                        io.imem_wdata <= {hi_q, io.in_data};
                        words_loaded  <= words_loaded + (ADDR_W + 1)'(1);
                        acc_q         <= acc_q ^ io.in_data;
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        if (chk_ok) begin
                            done <= 1'b1;
                        end else begin
                            error    <= 1'b1;
                            err_code <= ERR_CHK;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
